// File: rtl/vx_writeback_arbiter_pkg.sv
// rtl/vx_writeback_arbiter_pkg.sv - shared sizes, channel ids and writeback payload types
package vx_writeback_arbiter_pkg;

  localparam int NUM_REQS    = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int NR_BITS     = 5;
  localparam int DATA_W      = 32;
  localparam int PC_W        = 32;

  // Index width with a floor of one bit so single-entry configs still elaborate.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NW_BITS  = idx_bits(NUM_WARPS);
  localparam int SRC_BITS = idx_bits(NUM_REQS);

  localparam logic [SRC_BITS-1:0] CH_ALU = SRC_BITS'(0);
  localparam logic [SRC_BITS-1:0] CH_LD  = SRC_BITS'(1);
  localparam logic [SRC_BITS-1:0] CH_CSR = SRC_BITS'(2);
  localparam logic [SRC_BITS-1:0] CH_FPU = SRC_BITS'(3);

  typedef struct packed {
    logic [NW_BITS-1:0]            wid;
    logic [NUM_THREADS-1:0]        tmask;
    logic [PC_W-1:0]               pc;
    logic [NR_BITS-1:0]            rd;
    logic [NUM_THREADS*DATA_W-1:0] data;
  } wb_payload_t;

  typedef struct packed {
    logic [SRC_BITS-1:0] src;
    wb_payload_t         payload;
  } wb_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/vx_writeback_arbiter_if.sv
// rtl/vx_writeback_arbiter_if.sv - commit input and writeback output bundle
interface vx_writeback_arbiter_if;
  import vx_writeback_arbiter_pkg::*;

  logic [NUM_REQS-1:0]                    cmt_valid;
  logic [NUM_REQS-1:0]                    cmt_ready;
  logic [NUM_REQS-1:0]                    cmt_wb;
  logic [NUM_REQS*NW_BITS-1:0]            cmt_wid;
  logic [NUM_REQS*NUM_THREADS-1:0]        cmt_tmask;
  logic [NUM_REQS*PC_W-1:0]               cmt_pc;
  logic [NUM_REQS*NR_BITS-1:0]            cmt_rd;
  logic [NUM_REQS*NUM_THREADS*DATA_W-1:0] cmt_data;

  logic                          wb_valid;
  logic                          wb_ready;
  logic [NW_BITS-1:0]            wb_wid;
  logic [NUM_THREADS-1:0]        wb_tmask;
  logic [PC_W-1:0]               wb_pc;
  logic [NR_BITS-1:0]            wb_rd;
  logic [NUM_THREADS*DATA_W-1:0] wb_data;
  logic [SRC_BITS-1:0]           wb_src;

  modport master (
    output cmt_valid, cmt_wb, cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_data, wb_ready,
    input  cmt_ready, wb_valid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_src
  );

  modport slave (
    input  cmt_valid, cmt_wb, cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_data, wb_ready,
    output cmt_ready, wb_valid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_src
  );

endinterface

// File: rtl/vx_rr_skid_buf.sv
// rtl/vx_rr_skid_buf.sv - 2-entry elastic buffer whose in_ready comes straight from state
module vx_rr_skid_buf
  import vx_writeback_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic             push;
  logic             pop;

  assign in_ready_o  = (state_q != BUF_FULL);
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = main_q;
  assign busy_o      = out_valid_o;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          main_d  = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        // Drain and refill in one cycle keeps main occupied at full rate.
        if (push && pop) begin
          main_d = in_data_i;
        end else if (push) begin
          ovf_d   = in_data_i;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          main_d  = ovf_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// rtl/vx_writeback_arbiter.sv - round-robin merge of commit streams into one registered writeback port
module vx_writeback_arbiter
  import vx_writeback_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  vx_writeback_arbiter_if.slave  bus,
  output logic                   busy
);

  localparam int LANE_W = NUM_THREADS * DATA_W;
  localparam int ENT_W  = $bits(wb_entry_t);

  logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQS-1:0] cand;
  logic [NUM_REQS-1:0] grant;
  logic [SRC_BITS-1:0] gidx;
  logic [SRC_BITS-1:0] idx;
  logic                found;
  logic                in_ready;
  logic                accept;
  wb_entry_t           in_entry;
  wb_entry_t           out_entry;
  logic                out_valid;

  assign cand = bus.cmt_valid & bus.cmt_wb;

  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = SRC_BITS'((int'(rr_ptr_q) + k) % NUM_REQS);
      if (!found && cand[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign accept = found & in_ready;

  // Non-writeback commits bypass arbitration so stores/branches never wait on the register port.
  assign bus.cmt_ready = ~bus.cmt_wb | (grant & {NUM_REQS{in_ready}});

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = SRC_BITS'((int'(gidx) + 1) % NUM_REQS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    in_entry               = '0;
    in_entry.src           = gidx;
    in_entry.payload.wid   = bus.cmt_wid[int'(gidx)*NW_BITS +: NW_BITS];
    in_entry.payload.tmask = bus.cmt_tmask[int'(gidx)*NUM_THREADS +: NUM_THREADS];
    in_entry.payload.pc    = bus.cmt_pc[int'(gidx)*PC_W +: PC_W];
    in_entry.payload.rd    = bus.cmt_rd[int'(gidx)*NR_BITS +: NR_BITS];
    in_entry.payload.data  = bus.cmt_data[int'(gidx)*LANE_W +: LANE_W];
  end

  vx_rr_skid_buf #(
    .WIDTH (ENT_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (found),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (bus.wb_ready),
    .out_data_o  (out_entry),
    .busy_o      (busy)
  );

  assign bus.wb_valid = out_valid;
  assign bus.wb_src   = out_entry.src;
  assign bus.wb_wid   = out_entry.payload.wid;
  assign bus.wb_tmask = out_entry.payload.tmask;
  assign bus.wb_pc    = out_entry.payload.pc;
  assign bus.wb_rd    = out_entry.payload.rd;
  assign bus.wb_data  = out_entry.payload.data;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_stall_chk
    assert property (@(posedge clk) disable iff (reset)
      (bus.cmt_valid[i] && !bus.cmt_ready[i]) |=>
        $stable({bus.cmt_wid[i*NW_BITS +: NW_BITS],
                 bus.cmt_tmask[i*NUM_THREADS +: NUM_THREADS],
                 bus.cmt_pc[i*PC_W +: PC_W],
                 bus.cmt_rd[i*NR_BITS +: NR_BITS],
                 bus.cmt_data[i*LANE_W +: LANE_W]}));
  end

endmodule
